traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

Passive checker on the three-bit one-hot lights bus (R G Y: 100, 010, 001) driven by the traffic light controller. It samples the bus every clock and decodes the current phase. It checks encoding, phase order (RED→GREEN→YELLOW→RED) and per-phase dwell time against the controller's timing parameters, and latches the first fault for diagnosis. It counts completed, fully legal light cycles for system-level bring-up and regression benches.

## Interface
- RED_TIME, 5: controller RED parameter; legal RED dwell is RED_TIME+1 cycles.
- GREEN_TIME, 5: controller GREEN parameter; legal GREEN dwell is GREEN_TIME+1 cycles.
- YELLOW_TIME, 2: controller YELLOW parameter; legal YELLOW dwell is YELLOW_TIME+1 cycles.
- CNT_W, 8: dwell counter width; each X_TIME+1 must be < 2^CNT_W.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- lights  in  3  observed bus, [2]=R [1]=G [0]=Y.
- phase  out  2  registered decode: 00 RED, 01 GREEN, 10 YELLOW, 11 invalid.
- locked  out  1  high while tracking dwell (TRACK state).
- fault  out  1  sticky; high in FAULT state.
- err_code  out  3  first fault: 0 none, 1 ENCODING, 2 SEQUENCE, 3 DWELL_SHORT, 4 DWELL_LONG; held until reset.
- err_pulse  out  1  one-cycle strobe when the fault is first detected.
- cycle_count  out  16  completed legal YELLOW→RED transitions; wraps 0xFFFF→0.

## Operation
- States: SYNC, TRACK, FAULT.
  - Reset enters SYNC.
  - Reset values: phase=11, locked=0, fault=0, err_code=0, err_pulse=0, cycle_count=0, dwell=0, prev phase=invalid.
- Encoding check, applies in every state except FAULT:
  - Any lights value other than 100/010/001 raises ENCODING and moves to FAULT.
  - ENCODING has priority over all other checks in the same sample.
- SYNC:
  - Start-up alignment; dwell of the first observed phase is not checked.
  - A change to the legal successor phase moves to TRACK, sets locked=1, dwell=1.
  - A change to an illegal phase raises SEQUENCE and moves to FAULT.
  - The first valid sample after reset only records prev phase.
- TRACK, with E = expected dwell of the current phase (X_TIME+1):
  - Same phase sampled, dwell==E: raise DWELL_LONG, go to FAULT. This fires on sample E+1.
  - Same phase sampled, otherwise: dwell increments.
  - Phase change to an illegal successor: raise SEQUENCE, go to FAULT. SEQUENCE has priority over the dwell check.
  - Phase change to the legal successor with dwell<E: raise DWELL_SHORT, go to FAULT.
  - Phase change to the legal successor with dwell==E: legal transition; dwell=1. If the transition is YELLOW→RED, cycle_count increments.
- FAULT:
  - err_code and fault are frozen; locked=0.
  - lights is still decoded onto phase; no further checks, counting or pulses.
  - Exit only via reset.
- Dwell counter saturates at 2^CNT_W−1. It cannot exceed E+1 in practice.

## Timing
- All outputs are registered. The sample taken at edge N is reflected on outputs after edge N (one-cycle latency from lights change to output).
- err_pulse is high for exactly the cycle after the detecting edge. err_code, fault and locked=0 update on that same edge.
- locked rises on the edge that samples the first legal transition.
- cycle_count updates on the edge sampling RED after a legal YELLOW dwell.
- Reset asserted at any time, including mid-phase or in FAULT: on the next edge all outputs return to reset values and the state is SYNC. The first sample after reset deassertion is treated as a SYNC first sample.
- A controller reset seen without a monitor reset shows up as a YELLOW→RED or GREEN→RED jump and must flag SEQUENCE or DWELL_SHORT accordingly.

## Test plan
- Nominal: after reset, drive 100×6, 010×6, 001×3, repeated 3 times, then 100. Required: locked=1 from the first 010 sample; err_code=0; fault=0; cycle_count=3.
- Mid-phase sync: drive 100×2 then the nominal pattern. Required: no dwell error on the short initial RED; locked=1 on the first 010 sample.
- Sequence: while locked, drive 100×6 then 001. Required: err_code=2, one-cycle err_pulse, fault=1, locked=0; cycle_count unchanged.
- Dwell: GREEN held 4 samples then 001 → err_code=3. Separately, YELLOW held 4 samples → err_code=4, with err_pulse the cycle after the 4th 001 sample.
- Encoding: drive 011 in SYNC, and 000 while locked. Required: err_code=1 both times; fault sticky; later legal traffic leaves err_code unchanged.
- Reset mid-FAULT and cycle_count wrap: assert reset for 1 cycle → all outputs cleared next cycle. Preload via 65536 legal cycles (or force) → cycle_count wraps to 0 with no fault.

Source files
------------

// File: rtl/traffic_light_monitor_if.sv
// Lights bus as seen by the traffic light monitor, plus the monitor's diagnostics.
// Ports: lights (R/G/Y one-hot, driven by the controller side), phase, locked,
//        fault, err_code, err_pulse, cycle_count (driven by the monitor).
interface traffic_light_monitor_if;
  logic [2:0]  lights;
  logic [1:0]  phase;
  logic        locked;
  logic        fault;
  logic [2:0]  err_code;
  logic        err_pulse;
  logic [15:0] cycle_count;

  // master: the side that drives the lights and reads the diagnostics
  modport master (
    output lights,
    input  phase, locked, fault, err_code, err_pulse, cycle_count
  );

  // slave: the monitor itself
  modport slave (
    input  lights,
    output phase, locked, fault, err_code, err_pulse, cycle_count
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker for the one-hot traffic light bus: encoding, phase order,
// per-phase dwell; latches the first fault and counts legal light cycles.
// Ports: clk, reset (sync, active-high), mon (slave modport: lights in,
//        phase/locked/fault/err_code/err_pulse/cycle_count out). All outputs
//        registered, one cycle after the sampling edge.
module traffic_light_monitor #(
  parameter int RED_TIME    = 5,
  parameter int GREEN_TIME  = 5,
  parameter int YELLOW_TIME = 2,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  traffic_light_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    PH_RED    = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10,
    PH_INV    = 2'b11
  } phase_e;

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    E_NONE  = 3'd0,
    E_ENC   = 3'd1,
    E_SEQ   = 3'd2,
    E_SHORT = 3'd3,
    E_LONG  = 3'd4
  } err_e;

  // Legal dwell of each phase, in samples.
  localparam logic [CNT_W-1:0] RED_E    = CNT_W'(RED_TIME + 1);
  localparam logic [CNT_W-1:0] GREEN_E  = CNT_W'(GREEN_TIME + 1);
  localparam logic [CNT_W-1:0] YELLOW_E = CNT_W'(YELLOW_TIME + 1);
  localparam logic [CNT_W-1:0] DWELL_SAT = {CNT_W{1'b1}};

  state_e           state_q;
  phase_e           phase_q;      // decode of the previous sample (doubles as prev phase)
  logic [CNT_W-1:0] dwell_q;
  logic             locked_q;
  logic             fault_q;
  err_e             err_code_q;
  logic             err_pulse_q;
  logic [15:0]      cycle_count_q;

  phase_e           cur_ph;
  phase_e           succ_ph;
  logic [CNT_W-1:0] exp_dwell;
  logic [CNT_W-1:0] dwell_d;
  err_e             err_d;

  always_comb begin
    cur_ph = PH_INV;
    case (mon.lights)
      3'b100:  cur_ph = PH_RED;
      3'b010:  cur_ph = PH_GREEN;
      3'b001:  cur_ph = PH_YELLOW;
      default: cur_ph = PH_INV;
    endcase

    succ_ph   = PH_INV;
    exp_dwell = DWELL_SAT;
    case (phase_q)
      PH_RED:    begin succ_ph = PH_GREEN;  exp_dwell = RED_E;    end
      PH_GREEN:  begin succ_ph = PH_YELLOW; exp_dwell = GREEN_E;  end
      PH_YELLOW: begin succ_ph = PH_RED;    exp_dwell = YELLOW_E; end
      default:   begin succ_ph = PH_INV;    exp_dwell = DWELL_SAT; end
    endcase

    dwell_d = (dwell_q == DWELL_SAT) ? dwell_q : dwell_q + 1'b1;

    // Check priority: encoding, then sequence, then dwell.
    err_d = E_NONE;
    case (state_q)
      S_SYNC: begin
        if (cur_ph == PH_INV)
          err_d = E_ENC;
        else if (phase_q != PH_INV && cur_ph != phase_q && cur_ph != succ_ph)
          err_d = E_SEQ;
      end
      S_TRACK: begin
        if (cur_ph == PH_INV)
          err_d = E_ENC;
        else if (cur_ph == phase_q) begin
          if (dwell_q == exp_dwell)
            err_d = E_LONG;
        end
        else if (cur_ph != succ_ph)
          err_d = E_SEQ;
        else if (dwell_q < exp_dwell)
          err_d = E_SHORT;
      end
      default: err_d = E_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_SYNC;
      phase_q       <= PH_INV;
      dwell_q       <= '0;
      locked_q      <= 1'b0;
      fault_q       <= 1'b0;
      err_code_q    <= E_NONE;
      err_pulse_q   <= 1'b0;
      cycle_count_q <= 16'd0;
    end
    else begin
      phase_q     <= cur_ph;
      err_pulse_q <= 1'b0;
      if (err_d != E_NONE) begin
        state_q     <= S_FAULT;
        fault_q     <= 1'b1;
        locked_q    <= 1'b0;
        err_code_q  <= err_d;
        err_pulse_q <= 1'b1;
      end
      else begin
        case (state_q)
          S_SYNC: begin
            // No error here means any change is to the legal successor.
            // An invalid prev phase is the first sample after reset.
            if (phase_q != PH_INV && cur_ph != phase_q) begin
              state_q  <= S_TRACK;
              locked_q <= 1'b1;
              dwell_q  <= CNT_W'(1);
            end
          end
          S_TRACK: begin
            if (cur_ph == phase_q)
              dwell_q <= dwell_d;
            else begin
              dwell_q <= CNT_W'(1);
              if (phase_q == PH_YELLOW)
                cycle_count_q <= cycle_count_q + 16'd1;
            end
          end
          S_FAULT: locked_q <= 1'b0;
          default: state_q  <= S_SYNC;
        endcase
      end
    end
  end

  assign mon.phase       = phase_q;
  assign mon.locked      = locked_q;
  assign mon.fault       = fault_q;
  assign mon.err_code    = err_code_q;
  assign mon.err_pulse   = err_pulse_q;
  assign mon.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  traffic_light_monitor_if tl();

  traffic_light_monitor #(
    .RED_TIME(5), .GREEN_TIME(5), .YELLOW_TIME(2), .CNT_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (tl.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: phases 0=RED 1=GREEN 2=YELLOW 3=invalid; successor is (p+1)%3.
  int          exp_len [3] = '{6, 6, 3};
  int          m_prev;
  int          m_run;
  bit          m_locked, m_fault, m_pulse;
  int          m_err;
  logic [15:0] m_cycles;

  logic [2:0] stim[$];
  logic [23:0] obs;
  assign obs = {tl.phase, tl.locked, tl.fault, tl.err_code, tl.err_pulse, tl.cycle_count};

  localparam logic [23:0] RESET_VEC = 24'hC00000;

  function automatic logic [23:0] exp_vec();
    return {2'(m_prev), m_locked, m_fault, 3'(m_err), m_pulse, m_cycles};
  endfunction

  function automatic int decode(input logic [2:0] l);
    if (l == 3'b100) return 0;
    if (l == 3'b010) return 1;
    if (l == 3'b001) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    m_prev = 3; m_run = 0; m_locked = 0; m_fault = 0; m_pulse = 0; m_err = 0; m_cycles = 16'd0;
  endtask

  task automatic raise(input int code);
    m_err = code; m_fault = 1; m_locked = 0; m_pulse = 1;
  endtask

  task automatic model_sample(input logic [2:0] l);
    int p;
    p = decode(l);
    m_pulse = 0;
    if (!m_fault) begin
      if (p == 3) raise(1);
      else if (m_prev == 3) ;                    // first valid sample after reset
      else if (p == m_prev) begin
        if (m_locked) begin
          if (m_run == exp_len[p]) raise(4);
          else m_run++;
        end
      end
      else if (p != (m_prev + 1) % 3) raise(2);
      else if (m_locked && m_run < exp_len[m_prev]) raise(3);
      else begin
        if (m_locked && m_prev == 2) m_cycles = m_cycles + 16'd1;
        m_locked = 1;
        m_run = 1;
      end
    end
    m_prev = p;
  endtask

  task automatic sample(input logic [2:0] l);
    @(negedge clk);
    tl.lights = l;
    @(posedge clk);
    model_sample(l);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  task automatic add(input logic [2:0] l, input int n);
    for (int i = 0; i < n; i++) stim.push_back(l);
  endtask

  task automatic add_nominal(input int reps);
    for (int r = 0; r < reps; r++) begin
      add(3'b100, 6); add(3'b010, 6); add(3'b001, 3);
    end
  endtask

  task automatic test_reset();
    tl.lights = 3'b100;
    do_reset();
    n_checks++;
    if (obs !== RESET_VEC) $display("FAIL reset_state: got %h expected %h", obs, RESET_VEC);
    else n_pass++;
  endtask

  task automatic test_nominal();
    do_reset();
    stim.delete();
    add_nominal(3); add(3'b100, 1);
    foreach (stim[i]) begin
      sample(stim[i]);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL nominal[%0d]: got %h expected %h", i, obs, exp_vec());
      else n_pass++;
      if (i == 6) begin
        n_checks++;
        if (tl.locked !== 1'b1) $display("FAIL nominal_lock: got %b expected 1", tl.locked);
        else n_pass++;
      end
    end
    n_checks++;
    if ({tl.cycle_count, tl.fault, tl.err_code} !== {16'd3, 1'b0, 3'd0})
      $display("FAIL nominal_end: got cnt=%0d fault=%b err=%0d expected 3/0/0", tl.cycle_count, tl.fault, tl.err_code);
    else n_pass++;
  endtask

  task automatic test_mid_sync();
    do_reset();
    stim.delete();
    add(3'b100, 2); add_nominal(1); add(3'b100, 1);
    foreach (stim[i]) begin
      sample(stim[i]);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL mid_sync[%0d]: got %h expected %h", i, obs, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if ({tl.locked, tl.fault, tl.cycle_count} !== {1'b1, 1'b0, 16'd1})
      $display("FAIL mid_sync_end: got lock=%b fault=%b cnt=%0d expected 1/0/1", tl.locked, tl.fault, tl.cycle_count);
    else n_pass++;
  endtask

  task automatic test_sequence();
    do_reset();
    stim.delete();
    add(3'b001, 1); add(3'b100, 6); add(3'b001, 1); add(3'b010, 1);
    foreach (stim[i]) begin
      sample(stim[i]);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL sequence[%0d]: got %h expected %h", i, obs, exp_vec());
      else n_pass++;
      if (i == 7) begin
        n_checks++;
        if ({tl.err_code, tl.err_pulse, tl.fault, tl.locked, tl.cycle_count} !== {3'd2, 1'b1, 1'b1, 1'b0, 16'd0})
          $display("FAIL sequence_flag: got err=%0d pulse=%b fault=%b lock=%b cnt=%0d expected 2/1/1/0/0",
                   tl.err_code, tl.err_pulse, tl.fault, tl.locked, tl.cycle_count);
        else n_pass++;
      end
      if (i == 8) begin
        n_checks++;
        if ({tl.err_pulse, tl.err_code, tl.phase} !== {1'b0, 3'd2, 2'b01})
          $display("FAIL sequence_after: got pulse=%b err=%0d phase=%b expected 0/2/01", tl.err_pulse, tl.err_code, tl.phase);
        else n_pass++;
      end
    end
  endtask

  task automatic test_dwell();
    // GREEN held 4 samples, then YELLOW: too short.
    do_reset();
    stim.delete();
    add(3'b100, 1); add(3'b010, 4); add(3'b001, 1);
    foreach (stim[i]) begin
      sample(stim[i]);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL dwell_short[%0d]: got %h expected %h", i, obs, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if ({tl.err_code, tl.err_pulse} !== {3'd3, 1'b1})
      $display("FAIL dwell_short_code: got err=%0d pulse=%b expected 3/1", tl.err_code, tl.err_pulse);
    else n_pass++;

    // YELLOW held 4 samples: too long, flagged on the 4th.
    do_reset();
    stim.delete();
    add(3'b100, 2); add(3'b010, 6); add(3'b001, 4); add(3'b100, 1);
    foreach (stim[i]) begin
      sample(stim[i]);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL dwell_long[%0d]: got %h expected %h", i, obs, exp_vec());
      else n_pass++;
      if (i == 10 || i == 11) begin
        n_checks++;
        if (tl.err_pulse !== (i == 11))
          $display("FAIL dwell_long_pulse[%0d]: got %b expected %b", i, tl.err_pulse, (i == 11));
        else n_pass++;
      end
    end
    n_checks++;
    if ({tl.err_code, tl.fault} !== {3'd4, 1'b1})
      $display("FAIL dwell_long_code: got err=%0d fault=%b expected 4/1", tl.err_code, tl.fault);
    else n_pass++;
  endtask

  task automatic test_encoding();
    do_reset();
    stim.delete();
    add(3'b011, 1); add(3'b100, 6); add(3'b010, 6); add(3'b001, 3); add(3'b100, 1);
    foreach (stim[i]) begin
      sample(stim[i]);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL enc_sync[%0d]: got %h expected %h", i, obs, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if ({tl.err_code, tl.fault, tl.locked, tl.cycle_count} !== {3'd1, 1'b1, 1'b0, 16'd0})
      $display("FAIL enc_sync_hold: got err=%0d fault=%b lock=%b cnt=%0d expected 1/1/0/0",
               tl.err_code, tl.fault, tl.locked, tl.cycle_count);
    else n_pass++;

    do_reset();
    stim.delete();
    add(3'b100, 1); add(3'b010, 2); add(3'b000, 1); add(3'b001, 2);
    foreach (stim[i]) begin
      sample(stim[i]);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL enc_locked[%0d]: got %h expected %h", i, obs, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if ({tl.err_code, tl.fault, tl.phase} !== {3'd1, 1'b1, 2'b10})
      $display("FAIL enc_locked_hold: got err=%0d fault=%b phase=%b expected 1/1/10", tl.err_code, tl.fault, tl.phase);
    else n_pass++;
  endtask

  task automatic test_reset_in_fault();
    do_reset();
    sample(3'b111);
    do_reset();
    n_checks++;
    if (obs !== RESET_VEC) $display("FAIL reset_in_fault: got %h expected %h", obs, RESET_VEC);
    else n_pass++;
    sample(3'b010);
    sample(3'b001);
    n_checks++;
    if ({tl.locked, tl.fault, tl.phase} !== {1'b1, 1'b0, 2'b10})
      $display("FAIL resync_after_reset: got lock=%b fault=%b phase=%b expected 1/0/10", tl.locked, tl.fault, tl.phase);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    sample(3'b100);
    sample(3'b010);
    force dut.cycle_count_q = 16'hFFFE;
    #1;
    release dut.cycle_count_q;
    m_cycles = 16'hFFFE;
    stim.delete();
    add(3'b010, 5); add(3'b001, 3); add(3'b100, 6); add(3'b010, 6); add(3'b001, 3); add(3'b100, 1);
    foreach (stim[i]) begin
      sample(stim[i]);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL wrap[%0d]: got %h expected %h", i, obs, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if ({tl.cycle_count, tl.fault} !== {16'd0, 1'b0})
      $display("FAIL wrap_end: got cnt=%h fault=%b expected 0000/0", tl.cycle_count, tl.fault);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 24; r++) begin
      int p;
      do_reset();
      stim.delete();
      p = $urandom_range(0, 2);
      for (int k = 0; k < 8; k++) begin
        int n, sel;
        logic [2:0] l, g;
        n = exp_len[p];
        sel = $urandom_range(0, 15);
        if (sel == 0) n = n - 1;
        else if (sel == 1) n = n + 1;
        if (k == 0) n = $urandom_range(1, exp_len[p]);
        l = 3'b100 >> p;
        add(l, n);
        sel = $urandom_range(0, 31);
        if (sel == 0) begin
          g = 3'($urandom_range(0, 7));
          if (decode(g) != 3) g = 3'b000;
          add(g, 1);
        end
        if (sel == 1) p = (p + 2) % 3;
        else p = (p + 1) % 3;
      end
      foreach (stim[i]) begin
        sample(stim[i]);
        n_checks++;
        if (obs !== exp_vec()) $display("FAIL random[%0d][%0d]: got %h expected %h", r, i, obs, exp_vec());
        else n_pass++;
      end
    end
  endtask

  initial begin
    tl.lights = 3'b000;
    model_reset();
    test_reset();
    test_nominal();
    test_mid_sync();
    test_sequence();
    test_dwell();
    test_encoding();
    test_reset_in_fault();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
